dds_input_pio: RTL

Avalon-MM slave input port for front-panel push-buttons and the output-relay fault/feedback lines of the DDS function generator. It synchronises and debounces each input bit and latches edges into a sticky edge-capture register. It raises a maskable interrupt to the Nios II. It sits on the processor's data bus beside the DDS output-control PIOs and is the read-side counterpart to them.

---
 rtl/dds_input_pio.sv | 117 +++++++++++
 1 files changed

// File: rtl/dds_input_pio.sv
// Avalon-MM input PIO for DDS front-panel buttons and relay feedback.
// Per-bit sync + debounce, sticky edge capture, maskable level irq.
module dds_input_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter logic [31:0] INIT_STATE      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT =
    INIT_STATE[WIDTH-1:0];

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] ecap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      wd_unused;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr_en;

  assign wr_en     = chipselect && !write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign wd_unused = writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Any sample matching deb restarts that bit's count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= INIT;
      for (int i = 0; i < int'(WIDTH); i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      deb_q <= INIT;
    else
      deb_q <= deb;
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = deb & ~deb_q;
      1:       edge_det = ~deb & deb_q;
      default: edge_det = deb ^ deb_q;
    endcase
  end

  assign clr = (wr_en && address == 2'd3)
             ? wdata : '0;

  // Edge is OR-ed after the clear so it wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecap <= '0;
      mask <= '0;
    end else begin
      ecap <= (ecap & ~clr) | edge_det;
      if (wr_en && address == 2'd2)
        mask <= wdata;
    end
  end

  assign irq = |(ecap & mask);

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = 32'(deb);
      2'd1: readdata = '0;
      2'd2: readdata = 32'(mask);
      2'd3: readdata = 32'(ecap);
    endcase
  end

endmodule
